// File: rtl/hazard_unit_sb_pkg.sv
// Shared types for the RV32 hazard controller: write-back source encodings,
// hazard cause and the control vector each cause maps to.
package hazard_unit_sb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREG_DEF  = 32;
  localparam int RW_DEF    = $clog2(NREG_DEF);
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    WD_ALU  = 2'd0,
    WD_DRAM = 2'd1,
    WD_PC4  = 2'd2,
    WD_IMM  = 2'd3
  } wd_sel_e;

  typedef enum logic [1:0] {
    HZ_NONE = 2'd0,
    HZ_MEM  = 2'd1,
    HZ_BR   = 2'd2,
    HZ_DATA = 2'd3
  } hz_cause_e;

  typedef struct packed {
    logic keep_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic flush_if_id;
    logic flush_id_ex;
  } hz_ctrl_t;

  // A redirect discards the wrong-path instruction in ID, so it never stalls.
  function automatic hz_ctrl_t ctrl_for(input hz_cause_e cause);
    hz_ctrl_t c;
    c = '0;
    case (cause)
      HZ_MEM: begin
        c.keep_pc      = 1'b1;
        c.stall_if_id  = 1'b1;
        c.stall_id_ex  = 1'b1;
        c.stall_ex_mem = 1'b1;
      end
      HZ_BR: begin
        c.flush_if_id = 1'b1;
        c.flush_id_ex = 1'b1;
      end
      HZ_DATA: begin
        c.keep_pc     = 1'b1;
        c.stall_if_id = 1'b1;
        c.flush_id_ex = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_unit_sb_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
interface hazard_unit_sb_if
  import hazard_unit_sb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  localparam int RW = $clog2(NREG);

  logic            rs1_used_ID;
  logic            rs2_used_ID;
  logic [RW-1:0]   rR1_ID;
  logic [RW-1:0]   rR2_ID;
  logic            valid_EX;
  logic [RW-1:0]   wR_EX;
  logic [RW-1:0]   wR_MEM;
  logic [RW-1:0]   wR_WB;
  logic            rf_we_EX;
  logic            rf_we_MEM;
  logic            rf_we_WB;
  logic [XLEN-1:0] rf_wd_EX;
  logic [XLEN-1:0] rf_wd_MEM;
  logic [XLEN-1:0] rf_wd_WB;
  logic            long_EX;
  logic            lr_wb_valid;
  logic [RW-1:0]   lr_wb_rd;
  logic            mem_stall;
  logic            take_branch_EX;
  logic            cnt_clr;

  logic            keep_pc;
  logic            stall_IF_ID;
  logic            stall_ID_EX;
  logic            stall_EX_MEM;
  logic            flush_IF_ID;
  logic            flush_ID_EX;
  logic            fwd_rD1e_EX;
  logic            fwd_rD2e_EX;
  logic [XLEN-1:0] fwd_rD1_EX;
  logic [XLEN-1:0] fwd_rD2_EX;
  logic [NREG-1:0] sb_pending;
  logic [CNT_W-1:0] cnt_stall;
  logic [CNT_W-1:0] cnt_flush;
  logic [CNT_W-1:0] cnt_lduse;

  modport master (
    output rs1_used_ID, rs2_used_ID, rR1_ID, rR2_ID, valid_EX,
           wR_EX, wR_MEM, wR_WB, rf_we_EX, rf_we_MEM, rf_we_WB,
           rf_wd_EX, rf_wd_MEM, rf_wd_WB, long_EX, lr_wb_valid, lr_wb_rd,
           mem_stall, take_branch_EX, cnt_clr,
    input  keep_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM, flush_IF_ID,
           flush_ID_EX, fwd_rD1e_EX, fwd_rD2e_EX, fwd_rD1_EX, fwd_rD2_EX,
           sb_pending, cnt_stall, cnt_flush, cnt_lduse
  );

  modport slave (
    input  rs1_used_ID, rs2_used_ID, rR1_ID, rR2_ID, valid_EX,
           wR_EX, wR_MEM, wR_WB, rf_we_EX, rf_we_MEM, rf_we_WB,
           rf_wd_EX, rf_wd_MEM, rf_wd_WB, long_EX, lr_wb_valid, lr_wb_rd,
           mem_stall, take_branch_EX, cnt_clr,
    output keep_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM, flush_IF_ID,
           flush_ID_EX, fwd_rD1e_EX, fwd_rD2e_EX, fwd_rD1_EX, fwd_rD2_EX,
           sb_pending, cnt_stall, cnt_flush, cnt_lduse
  );

endinterface

// File: rtl/hazard_unit_sb_scoreboard.sv
// Pending-write scoreboard for long-latency results: one bit per register,
// with same-cycle write-back bypass detection for both ID sources.
module hazard_scoreboard #(
  parameter int NREG = 32,
  parameter int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [RW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [RW-1:0]   clr_idx,
  input  logic            rs1_used,
  input  logic            rs2_used,
  input  logic [RW-1:0]   rr1,
  input  logic [RW-1:0]   rr2,
  output logic [NREG-1:0] sb_pending,
  output logic            hit1,
  output logic            hit2,
  output logic            byp1,
  output logic            byp2
);

  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_nxt;

  // Set is applied after clear so a new long-latency writer wins the tie.
  always_comb begin
    sb_nxt = sb_q;
    if (clr_en && clr_idx != '0) sb_nxt[clr_idx] = 1'b0;
    if (set_en && set_idx != '0) sb_nxt[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_nxt;
  end

  assign sb_pending = sb_q;
  assign hit1 = rs1_used && sb_q[rr1];
  assign hit2 = rs2_used && sb_q[rr2];
  assign byp1 = hit1 && clr_en && (clr_idx == rr1);
  assign byp2 = hit2 && clr_en && (clr_idx == rr2);

endmodule

// File: rtl/hazard_unit_sb.sv
// Hazard controller for the 5-stage RV32 core: EX>MEM>WB forwarding, scoreboard
// stalls for long-latency loads, memory freeze, branch flush and perf counters.
module hazard_unit_sb
  import hazard_unit_sb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic             clk,
  input logic             rst_n,
  hazard_unit_sb_if.slave hz
);

  localparam int RW = $clog2(NREG);

  function automatic logic raw(input logic used, input logic [RW-1:0] rr,
                               input logic [RW-1:0] wr, input logic we);
    return used && (rr == wr) && we && (wr != '0);
  endfunction

  // A pending scoreboard bit means MEM/WB hold stale data for that register.
  function automatic logic [XLEN:0] fwd_pick(input logic hit_ex, input logic byp,
                                             input logic sb_blk, input logic hit_mem,
                                             input logic hit_wb,
                                             input logic [XLEN-1:0] d_ex,
                                             input logic [XLEN-1:0] d_mem,
                                             input logic [XLEN-1:0] d_wb);
    logic [XLEN:0] r;
    r = '0;
    if (hit_ex)                  r = {1'b1, d_ex};
    else if (byp)                r = {1'b1, d_wb};
    else if (!sb_blk && hit_mem) r = {1'b1, d_mem};
    else if (!sb_blk && hit_wb)  r = {1'b1, d_wb};
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  logic raw_ex1, raw_ex2, raw_mem1, raw_mem2, raw_wb1, raw_wb2;
  logic hit1, hit2, byp1, byp2;
  logic sb_set, data_haz;
  logic [XLEN:0] fwd1, fwd2;
  hz_cause_e cause;
  hz_ctrl_t  ctrl;
  logic [CNT_W-1:0] cnt_stall_r, cnt_flush_r, cnt_lduse_r;

  assign raw_ex1  = raw(hz.rs1_used_ID, hz.rR1_ID, hz.wR_EX,  hz.rf_we_EX);
  assign raw_ex2  = raw(hz.rs2_used_ID, hz.rR2_ID, hz.wR_EX,  hz.rf_we_EX);
  assign raw_mem1 = raw(hz.rs1_used_ID, hz.rR1_ID, hz.wR_MEM, hz.rf_we_MEM);
  assign raw_mem2 = raw(hz.rs2_used_ID, hz.rR2_ID, hz.wR_MEM, hz.rf_we_MEM);
  assign raw_wb1  = raw(hz.rs1_used_ID, hz.rR1_ID, hz.wR_WB,  hz.rf_we_WB);
  assign raw_wb2  = raw(hz.rs2_used_ID, hz.rR2_ID, hz.wR_WB,  hz.rf_we_WB);

  assign sb_set = !hz.mem_stall && hz.valid_EX && hz.long_EX &&
                  hz.rf_we_EX && (hz.wR_EX != '0);

  hazard_scoreboard #(.NREG(NREG), .RW(RW)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (sb_set),
    .set_idx    (hz.wR_EX),
    .clr_en     (hz.lr_wb_valid),
    .clr_idx    (hz.lr_wb_rd),
    .rs1_used   (hz.rs1_used_ID),
    .rs2_used   (hz.rs2_used_ID),
    .rr1        (hz.rR1_ID),
    .rr2        (hz.rR2_ID),
    .sb_pending (hz.sb_pending),
    .hit1       (hit1),
    .hit2       (hit2),
    .byp1       (byp1),
    .byp2       (byp2)
  );

  assign fwd1 = fwd_pick(raw_ex1, byp1, hit1, raw_mem1, raw_wb1,
                         hz.rf_wd_EX, hz.rf_wd_MEM, hz.rf_wd_WB);
  assign fwd2 = fwd_pick(raw_ex2, byp2, hit2, raw_mem2, raw_wb2,
                         hz.rf_wd_EX, hz.rf_wd_MEM, hz.rf_wd_WB);
  assign {hz.fwd_rD1e_EX, hz.fwd_rD1_EX} = fwd1;
  assign {hz.fwd_rD2e_EX, hz.fwd_rD2_EX} = fwd2;

  assign data_haz = (hz.long_EX && hz.valid_EX && (raw_ex1 || raw_ex2)) ||
                    (hit1 && !byp1) || (hit2 && !byp2);

  always_comb begin
    cause = HZ_NONE;
    if (hz.mem_stall)           cause = HZ_MEM;
    else if (hz.take_branch_EX) cause = HZ_BR;
    else if (data_haz)          cause = HZ_DATA;
  end

  assign ctrl            = ctrl_for(cause);
  assign hz.keep_pc      = ctrl.keep_pc;
  assign hz.stall_IF_ID  = ctrl.stall_if_id;
  assign hz.stall_ID_EX  = ctrl.stall_id_ex;
  assign hz.stall_EX_MEM = ctrl.stall_ex_mem;
  assign hz.flush_IF_ID  = ctrl.flush_if_id;
  assign hz.flush_ID_EX  = ctrl.flush_id_ex;

  // Counter stage: one cycle behind the cause that bumps it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_stall_r <= '0;
      cnt_flush_r <= '0;
      cnt_lduse_r <= '0;
    end else if (hz.cnt_clr) begin
      cnt_stall_r <= '0;
      cnt_flush_r <= '0;
      cnt_lduse_r <= '0;
    end else begin
      if (ctrl.keep_pc)      cnt_stall_r <= sat_inc(cnt_stall_r);
      if (cause == HZ_BR)    cnt_flush_r <= sat_inc(cnt_flush_r);
      if (cause == HZ_DATA)  cnt_lduse_r <= sat_inc(cnt_lduse_r);
    end
  end

  assign hz.cnt_stall = cnt_stall_r;
  assign hz.cnt_flush = cnt_flush_r;
  assign hz.cnt_lduse = cnt_lduse_r;

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed bench for hazard_unit_sb with 4-bit perf counters.
module tb_hazard_unit_sb;

  localparam int XLEN = 32, NREG = 32, CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] ctl;

  hazard_unit_sb_if #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) hz ();

  hazard_unit_sb #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  assign ctl = {hz.keep_pc, hz.stall_IF_ID, hz.stall_ID_EX, hz.stall_EX_MEM,
                hz.flush_IF_ID, hz.flush_ID_EX};

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    hz.rs1_used_ID = 0; hz.rs2_used_ID = 0; hz.rR1_ID = '0; hz.rR2_ID = '0;
    hz.valid_EX = 0; hz.wR_EX = '0; hz.wR_MEM = '0; hz.wR_WB = '0;
    hz.rf_we_EX = 0; hz.rf_we_MEM = 0; hz.rf_we_WB = 0;
    hz.rf_wd_EX = '0; hz.rf_wd_MEM = '0; hz.rf_wd_WB = '0;
    hz.long_EX = 0; hz.lr_wb_valid = 0; hz.lr_wb_rd = '0;
    hz.mem_stall = 0; hz.take_branch_EX = 0; hz.cnt_clr = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clr_cnt();
    idle(); hz.cnt_clr = 1; step(); hz.cnt_clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); #1;
    n_cmp++; if (hz.sb_pending !== 32'h0) begin n_bad++; $display("FAIL reset_sb got=%h exp=0", hz.sb_pending); end
    n_cmp++; if ({hz.cnt_stall, hz.cnt_flush, hz.cnt_lduse} !== 12'h000) begin n_bad++; $display("FAIL reset_cnts got=%h exp=000", {hz.cnt_stall, hz.cnt_flush, hz.cnt_lduse}); end
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL reset_ctl got=%b exp=000000", ctl); end
    hz.take_branch_EX = 1; #1;
    n_cmp++; if (ctl !== 6'b000011) begin n_bad++; $display("FAIL reset_comb_branch got=%b exp=000011", ctl); end
    idle();
    @(negedge clk); rst_n = 1; step();
  endtask

  task automatic test_forward();
    idle();
    hz.rs1_used_ID = 1; hz.rR1_ID = 7; hz.rs2_used_ID = 1; hz.rR2_ID = 9;
    hz.wR_EX = 7;  hz.rf_we_EX = 1;  hz.rf_wd_EX = 32'hAAAA_0001;
    hz.wR_MEM = 7; hz.rf_we_MEM = 1; hz.rf_wd_MEM = 32'hBBBB_0002;
    hz.wR_WB = 9;  hz.rf_we_WB = 1;  hz.rf_wd_WB = 32'hCCCC_0003;
    #1;
    n_cmp++; if ({hz.fwd_rD1e_EX, hz.fwd_rD1_EX} !== {1'b1, 32'hAAAA_0001}) begin n_bad++; $display("FAIL fwd_ex_over_mem got=%b/%h exp=1/aaaa0001", hz.fwd_rD1e_EX, hz.fwd_rD1_EX); end
    n_cmp++; if ({hz.fwd_rD2e_EX, hz.fwd_rD2_EX} !== {1'b1, 32'hCCCC_0003}) begin n_bad++; $display("FAIL fwd_wb got=%b/%h exp=1/cccc0003", hz.fwd_rD2e_EX, hz.fwd_rD2_EX); end
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL fwd_no_stall got=%b exp=000000", ctl); end
    hz.rR2_ID = 7; hz.rf_we_EX = 0; #1;
    n_cmp++; if ({hz.fwd_rD1e_EX, hz.fwd_rD1_EX} !== {1'b1, 32'hBBBB_0002}) begin n_bad++; $display("FAIL fwd_mem got=%b/%h exp=1/bbbb0002", hz.fwd_rD1e_EX, hz.fwd_rD1_EX); end
    hz.rs1_used_ID = 0; #1;
    n_cmp++; if ({hz.fwd_rD1e_EX, hz.fwd_rD1_EX} !== {1'b0, 32'h0}) begin n_bad++; $display("FAIL fwd_unused got=%b/%h exp=0/0", hz.fwd_rD1e_EX, hz.fwd_rD1_EX); end
    n_cmp++; if ({hz.fwd_rD2e_EX, hz.fwd_rD2_EX} !== {1'b1, 32'hBBBB_0002}) begin n_bad++; $display("FAIL fwd_mem_rs2 got=%b/%h exp=1/bbbb0002", hz.fwd_rD2e_EX, hz.fwd_rD2_EX); end
  endtask

  task automatic test_lduse();
    clr_cnt(); idle();
    hz.valid_EX = 1; hz.long_EX = 1; hz.rf_we_EX = 1; hz.wR_EX = 5;
    hz.rs1_used_ID = 1; hz.rR1_ID = 5; hz.rs2_used_ID = 1; hz.rR2_ID = 6;
    #1;
    n_cmp++; if (ctl !== 6'b110001) begin n_bad++; $display("FAIL lduse_ctl got=%b exp=110001", ctl); end
    step();
    n_cmp++; if (hz.sb_pending !== 32'h0000_0020) begin n_bad++; $display("FAIL lduse_sb got=%h exp=00000020", hz.sb_pending); end
    n_cmp++; if ({hz.cnt_stall, hz.cnt_flush, hz.cnt_lduse} !== {4'd1, 4'd0, 4'd1}) begin n_bad++; $display("FAIL lduse_cnts got=%h exp=101", {hz.cnt_stall, hz.cnt_flush, hz.cnt_lduse}); end
    idle(); hz.rs1_used_ID = 1; hz.rR1_ID = 5; #1;
    n_cmp++; if (ctl !== 6'b110001) begin n_bad++; $display("FAIL lduse_sb_hold got=%b exp=110001", ctl); end
  endtask

  task automatic test_mem_stall();
    clr_cnt();
    hz.rs1_used_ID = 1; hz.rR1_ID = 5; hz.mem_stall = 1;
    hz.valid_EX = 1; hz.long_EX = 1; hz.rf_we_EX = 1; hz.wR_EX = 8;
    #1;
    n_cmp++; if (ctl !== 6'b111100) begin n_bad++; $display("FAIL memstall_ctl got=%b exp=111100", ctl); end
    repeat (3) step();
    n_cmp++; if ({hz.cnt_stall, hz.cnt_lduse} !== {4'd3, 4'd0}) begin n_bad++; $display("FAIL memstall_cnts got=%h exp=30", {hz.cnt_stall, hz.cnt_lduse}); end
    n_cmp++; if (hz.sb_pending !== 32'h0000_0020) begin n_bad++; $display("FAIL memstall_sb got=%h exp=00000020", hz.sb_pending); end
  endtask

  task automatic test_clear_bypass();
    idle();
    hz.rs2_used_ID = 1; hz.rR2_ID = 5;
    hz.wR_MEM = 5; hz.rf_we_MEM = 1; hz.rf_wd_MEM = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if ({ctl, hz.fwd_rD2e_EX} !== {6'b110001, 1'b0}) begin n_bad++; $display("FAIL sb_suppress got=%b/%b exp=110001/0", ctl, hz.fwd_rD2e_EX); end
    hz.lr_wb_valid = 1; hz.lr_wb_rd = 5; hz.rf_wd_WB = 32'h1234_5678;
    hz.rs1_used_ID = 1; hz.rR1_ID = 5;
    #1;
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL bypass_ctl got=%b exp=000000", ctl); end
    n_cmp++; if ({hz.fwd_rD1e_EX, hz.fwd_rD1_EX} !== {1'b1, 32'h1234_5678}) begin n_bad++; $display("FAIL bypass_fwd1 got=%b/%h exp=1/12345678", hz.fwd_rD1e_EX, hz.fwd_rD1_EX); end
    n_cmp++; if (hz.fwd_rD2_EX !== 32'h1234_5678) begin n_bad++; $display("FAIL bypass_fwd2 got=%h exp=12345678", hz.fwd_rD2_EX); end
    step();
    n_cmp++; if (hz.sb_pending !== 32'h0) begin n_bad++; $display("FAIL bypass_sb_clr got=%h exp=0", hz.sb_pending); end
    idle();
    hz.valid_EX = 1; hz.long_EX = 1; hz.rf_we_EX = 1; hz.wR_EX = 6;
    hz.lr_wb_valid = 1; hz.lr_wb_rd = 6;
    step();
    n_cmp++; if (hz.sb_pending !== 32'h0000_0040) begin n_bad++; $display("FAIL set_wins got=%h exp=00000040", hz.sb_pending); end
    idle(); hz.lr_wb_valid = 1; hz.lr_wb_rd = 6;
    step();
    n_cmp++; if (hz.sb_pending !== 32'h0) begin n_bad++; $display("FAIL clr6 got=%h exp=0", hz.sb_pending); end
  endtask

  task automatic test_branch();
    clr_cnt(); idle();
    hz.valid_EX = 1; hz.long_EX = 1; hz.rf_we_EX = 1; hz.wR_EX = 5;
    hz.rs1_used_ID = 1; hz.rR1_ID = 5; hz.take_branch_EX = 1;
    #1;
    n_cmp++; if (ctl !== 6'b000011) begin n_bad++; $display("FAIL branch_ctl got=%b exp=000011", ctl); end
    step();
    n_cmp++; if ({hz.cnt_stall, hz.cnt_flush, hz.cnt_lduse} !== {4'd0, 4'd1, 4'd0}) begin n_bad++; $display("FAIL branch_cnts got=%h exp=010", {hz.cnt_stall, hz.cnt_flush, hz.cnt_lduse}); end
    idle(); hz.lr_wb_valid = 1; hz.lr_wb_rd = 5;
    step();
  endtask

  task automatic test_x0();
    idle();
    hz.valid_EX = 1; hz.long_EX = 1;
    hz.rf_we_EX = 1; hz.rf_we_MEM = 1; hz.rf_we_WB = 1;
    hz.rf_wd_EX = 32'h11; hz.rf_wd_MEM = 32'h22; hz.rf_wd_WB = 32'h33;
    hz.rs1_used_ID = 1; hz.rs2_used_ID = 1;
    #1;
    n_cmp++; if ({hz.fwd_rD1e_EX, hz.fwd_rD2e_EX, ctl} !== 8'h00) begin n_bad++; $display("FAIL x0_fwd got=%b%b/%b exp=00/000000", hz.fwd_rD1e_EX, hz.fwd_rD2e_EX, ctl); end
    step();
    n_cmp++; if (hz.sb_pending !== 32'h0) begin n_bad++; $display("FAIL x0_sb got=%h exp=0", hz.sb_pending); end
  endtask

  task automatic test_saturation();
    clr_cnt(); hz.mem_stall = 1;
    repeat (20) step();
    n_cmp++; if (hz.cnt_stall !== 4'hF) begin n_bad++; $display("FAIL sat_cnt got=%h exp=f", hz.cnt_stall); end
    hz.cnt_clr = 1; step(); hz.cnt_clr = 0;
    n_cmp++; if (hz.cnt_stall !== 4'h0) begin n_bad++; $display("FAIL clr_wins got=%h exp=0", hz.cnt_stall); end
  endtask

  task automatic test_reset_mid();
    idle();
    hz.valid_EX = 1; hz.long_EX = 1; hz.rf_we_EX = 1; hz.wR_EX = 9;
    step();
    idle(); hz.mem_stall = 1; hz.rs1_used_ID = 1; hz.rR1_ID = 9;
    repeat (2) step();
    n_cmp++; if ({hz.sb_pending, hz.cnt_stall} !== {32'h0000_0200, 4'd2}) begin n_bad++; $display("FAIL mid_pre got=%h/%h exp=00000200/2", hz.sb_pending, hz.cnt_stall); end
    rst_n = 0; idle(); #1;
    n_cmp++; if ({hz.sb_pending, hz.cnt_stall, hz.cnt_flush, hz.cnt_lduse, ctl} !== '0) begin n_bad++; $display("FAIL mid_reset got=%h/%h/%b exp=0", hz.sb_pending, {hz.cnt_stall, hz.cnt_flush, hz.cnt_lduse}, ctl); end
    step();
    @(negedge clk); rst_n = 1;
  endtask

  initial begin
    idle();
    test_reset();
    test_forward();
    test_lduse();
    test_mem_stall();
    test_clear_bypass();
    test_branch();
    test_x0();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
